mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Data-bus access controller directly downstream of the M-stage register. It turns the M-stage memory request (valid flag, address, byte strobe, size, store data) into a two-phase data-bus transaction: address accept, then data return. It stalls the pipeline until the transaction completes and returns load data to the M-stage. It drains transactions orphaned by a pipeline flush without handing their results back.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
m_vreq  in  1  M-stage needs a memory access this cycle
m_addr  in  ADDR_W  byte address
m_wstrb  in  DATA_W/8  byte write enables; all zero means load
m_wdata  in  DATA_W  store data, already lane-replicated
m_size  in  2  msize_t (MSIZE1/2/4)
m_advance  in  1  M-stage instruction moves to W this cycle
flush  in  1  pipeline flush (exception/interrupt); current M instruction is killed
m_data  out  DATA_W  load data for the M-stage
mem_stall  out  1  hold M and upstream stages
dreq_valid  out  1  bus request valid
dreq_addr  out  ADDR_W  request address
dreq_strobe  out  DATA_W/8  request strobe
dreq_size  out  2  request size
dreq_data  out  DATA_W  request write data
dresp_addr_ok  in  1  request accepted this cycle
dresp_data_ok  in  1  response (load data or store ack) this cycle
dresp_data  in  DATA_W  response data
stall_cnt  out  32  count of cycles with mem_stall=1

Behaviour:
- Clocking and reset: all state changes on posedge clk. Reset is synchronous, active-low (resetn) on clock clk.
- Reset values: state IDLE; discard 0; dreq_valid 0; dreq_addr/strobe/size/data 0; m_data 0; stall_cnt 0. Reset overrides any in-flight transaction; the bus slave shares the same reset.
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - m_vreq & !flush: latch addr, strobe, size, wdata into request registers; go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - dreq_valid=1; request fields are held stable until dresp_addr_ok.
  - addr_ok & data_ok in the same cycle: capture dresp_data; go to DONE, or to IDLE if discard.
  - addr_ok only: go to WAIT.
- WAIT
  - dreq_valid=0.
  - On data_ok: capture dresp_data into m_data (loads only; stores leave m_data unchanged); go to DONE, or to IDLE if discard.
- DONE
  - m_data stable.
  - On m_advance or flush: go to IDLE; clear discard.
- Flush rules:
  - Flush in REQ or WAIT sets discard=1.
  - A request already asserted is never withdrawn; it completes and its result is dropped.
  - Flush in IDLE suppresses a new request in that cycle.
- mem_stall (combinational):
  - IDLE: m_vreq & !flush.
  - REQ/WAIT with discard=0: 1.
  - REQ/WAIT with discard=1: m_vreq (a new instruction waits for the drain).
  - DONE: 0.
- Minimum latency: m_vreq seen in cycle 0 → dreq_valid in cycle 1 → addr_ok & data_ok in cycle 1 → DONE in cycle 2, with mem_stall=0 and m_data valid. This gives 2 stall cycles.
- Simultaneous flush and data_ok in REQ/WAIT: the response is discarded and the next state is IDLE.
- stall_cnt increments by 1 on each cycle with mem_stall=1 and wraps at 2^32.

Decomposition:
- Shared package: mem_state_t enum {IDLE, REQ, WAIT, DONE}; dreq_t struct (valid, addr, strobe, size, data); dresp_t struct (addr_ok, data_ok, data). msize_t is reused from the existing common header.
- No sub-module required; the FSM and request registers live in one module.

Test Plan:
- Load, zero-wait slave: m_vreq=1, m_addr=0x8000_0010, strobe=0, MSIZE4; slave gives addr_ok & data_ok in the first valid cycle with data 0xDEADBEEF → dreq_valid exactly 1 cycle; mem_stall=1 for 2 cycles; m_data=0xDEADBEEF in DONE.
- Store, delayed slave: strobe=4'b0011, wdata=0x12341234; addr_ok held off 3 cycles, data_ok 2 cycles after addr_ok → dreq fields stable all 4 valid cycles; dreq_valid drops after addr_ok; mem_stall low the cycle after data_ok.
- DONE hold: data_ok returns 0xA5A5A5A5 while m_advance=0 for 4 cycles → state stays DONE, mem_stall=0, m_data constant; on m_advance → IDLE; no new dreq_valid.
- Flush in WAIT: flush pulses one cycle after addr_ok; next M instruction asserts m_vreq → old data_ok (0x11111111) does not update m_data; mem_stall stays 1 until the drain ends; then a second dreq_valid is issued with the new address.
- Flush coincident with data_ok in REQ → next state IDLE, m_data unchanged, discard=0.
- Reset mid-transaction: resetn=0 in WAIT → next cycle IDLE, dreq_valid=0, mem_stall=0, stall_cnt=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types for the M-stage data-bus access controller
package mem_access_ctrl_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_STRB_W = PKG_DATA_W / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_STRB_W-1:0] strobe;
        msize_t                size;
        logic [PKG_DATA_W-1:0] data;
    } dreq_t;

    typedef struct packed {
        logic                  addr_ok;
        logic                  data_ok;
        logic [PKG_DATA_W-1:0] data;
    } dresp_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - two-phase data-bus transaction FSM with pipeline stall and flush drain
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m_vreq,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [1:0]          m_size,
    input  logic                m_advance,
    input  logic                flush,
    output logic [DATA_W-1:0]   m_data,
    output logic                mem_stall,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [1:0]          dreq_size,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic [31:0]         stall_cnt
);

    mem_state_t state, state_nx;
    logic       discard, discard_nx;
    logic       latch_req;
    logic       capture;
    logic       resp_done;
    logic       req_is_load;

    assign req_is_load = (dreq_strobe == '0);

    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        mem_stall  = 1'b0;
        dreq_valid = 1'b0;
        latch_req  = 1'b0;
        capture    = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = m_vreq & ~flush;
                if (m_vreq && !flush) begin
                    latch_req = 1'b1;
                    state_nx  = REQ;
                end
            end
            REQ, WAIT: begin
                dreq_valid = (state == REQ);
                // Once orphaned, only a waiting successor instruction keeps the pipe held.
                mem_stall  = discard ? m_vreq : 1'b1;
                if (flush) begin
                    discard_nx = 1'b1;
                end
                if (state == REQ) begin
                    resp_done = dresp_addr_ok & dresp_data_ok;
                    if (dresp_addr_ok && !dresp_data_ok) begin
                        state_nx = WAIT;
                    end
                end else begin
                    resp_done = dresp_data_ok;
                end
                if (resp_done) begin
                    if (discard || flush) begin
                        state_nx   = IDLE;
                        discard_nx = 1'b0;
                    end else begin
                        state_nx = DONE;
                        capture  = req_is_load;
                    end
                end
            end
            DONE: begin
                if (m_advance || flush) begin
                    state_nx   = IDLE;
                    discard_nx = 1'b0;
                end
            end
            default: begin
                state_nx   = IDLE;
                discard_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            discard     <= 1'b0;
            dreq_addr   <= '0;
            dreq_strobe <= '0;
            dreq_size   <= '0;
            dreq_data   <= '0;
            m_data      <= '0;
            stall_cnt   <= '0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
            if (latch_req) begin
                dreq_addr   <= m_addr;
                dreq_strobe <= m_wstrb;
                dreq_size   <= m_size;
                dreq_data   <= m_wdata;
            end
            if (capture) begin
                m_data <= dresp_data;
            end
            if (mem_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench with a transaction-level model
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_vreq;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        m_advance;
    logic        flush;
    logic [31:0] m_data;
    logic        mem_stall;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [1:0]  dreq_size;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .m_vreq(m_vreq), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_size(m_size),
        .m_advance(m_advance), .flush(flush), .m_data(m_data),
        .mem_stall(mem_stall), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_strobe(dreq_strobe), .dreq_size(dreq_size), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .stall_cnt(stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int dv_count = 0;
    bit chk_en = 1'b0;

    // Transaction-level view: one outstanding bus transaction that may be owned or orphaned.
    bit          md_on_bus = 0, md_taken = 0, md_killed = 0, md_held = 0;
    logic [31:0] md_mdata = '0, md_addr = '0, md_wdata = '0, md_cnt = '0;
    logic [3:0]  md_strb = '0;
    logic [1:0]  md_size = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_stall();
        if (md_held) return 1'b0;
        if (md_on_bus) return md_killed ? m_vreq : 1'b1;
        return m_vreq & ~flush;
    endfunction

    initial begin
        forever begin
            bit st, fin;
            @(negedge clk);
            st = exp_stall();
            if (chk_en) begin
                dv_count += int'(dreq_valid);
                chk("mem_stall", {31'd0, mem_stall}, {31'd0, st});
                chk("dreq_valid", {31'd0, dreq_valid}, {31'd0, md_on_bus & ~md_taken});
                chk("m_data", m_data, md_mdata);
                chk("stall_cnt", stall_cnt, md_cnt);
                if (md_on_bus && !md_taken) begin
                    chk("dreq_addr", dreq_addr, md_addr);
                    chk("dreq_strobe", {28'd0, dreq_strobe}, {28'd0, md_strb});
                    chk("dreq_size", {30'd0, dreq_size}, {30'd0, md_size});
                    chk("dreq_data", dreq_data, md_wdata);
                end
            end
            if (!resetn) begin
                md_on_bus = 0; md_taken = 0; md_killed = 0; md_held = 0;
                md_mdata = '0; md_cnt = '0;
            end else begin
                md_cnt += {31'd0, st};
                if (md_held) begin
                    if (m_advance || flush) md_held = 0;
                end else if (md_on_bus) begin
                    fin = dresp_data_ok && (md_taken || dresp_addr_ok);
                    if (dresp_addr_ok) md_taken = 1;
                    if (flush) md_killed = 1;
                    if (fin) begin
                        if (!md_killed && md_strb == 4'd0) md_mdata = dresp_data;
                        md_held = !md_killed;
                        md_on_bus = 0; md_taken = 0; md_killed = 0;
                    end
                end else if (m_vreq && !flush) begin
                    md_on_bus = 1;
                    md_addr = m_addr; md_strb = m_wstrb; md_size = m_size; md_wdata = m_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic [1:0] sz);
        m_vreq = 1'b1; m_addr = a; m_wstrb = s; m_wdata = d; m_size = sz;
    endtask

    task automatic resp(input logic aok, input logic dok, input logic [31:0] d);
        dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = d;
    endtask

    task automatic retire();
        m_advance = 1'b1;
        tick();
        m_advance = 1'b0; m_vreq = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0; m_vreq = 0; m_addr = '0; m_wstrb = '0; m_wdata = '0; m_size = '0;
        m_advance = 0; flush = 0; resp(0, 0, '0);
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rst_dreq_addr", dreq_addr, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        resetn = 1'b1;

        // Load against a zero-wait slave.
        issue(32'h8000_0010, 4'b0000, 32'h0, 2'd2);
        tick();
        resp(1, 1, 32'hDEAD_BEEF);
        tick();
        resp(0, 0, '0);
        #1;
        chk("ld0_m_data", m_data, 32'hDEAD_BEEF);
        chk("ld0_stall", {31'd0, mem_stall}, 32'd0);
        chk("ld0_stall_cnt", stall_cnt, 32'd2);
        chk("ld0_dv_cycles", dv_count, 32'd1);
        retire();

        // Store with addr_ok held off three cycles and data_ok two cycles later.
        issue(32'h8000_0020, 4'b0011, 32'h1234_1234, 2'd1);
        tick();
        repeat (3) tick();
        resp(1, 0, '0);
        tick();
        resp(0, 0, '0);
        tick();
        resp(0, 1, 32'hFFFF_FFFF);
        tick();
        resp(0, 0, '0);
        #1;
        chk("st_stall_after", {31'd0, mem_stall}, 32'd0);
        chk("st_m_data_kept", m_data, 32'hDEAD_BEEF);
        chk("st_dv_cycles", dv_count, 32'd5);
        chk("st_stall_cnt", stall_cnt, 32'd9);
        retire();

        // Result held in DONE while the M stage does not advance.
        issue(32'h8000_0030, 4'b0000, 32'h0, 2'd2);
        tick();
        resp(1, 0, '0);
        tick();
        resp(0, 1, 32'hA5A5_A5A5);
        tick();
        resp(0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_m_data", m_data, 32'hA5A5_A5A5);
            chk("hold_stall", {31'd0, mem_stall}, 32'd0);
            tick();
        end
        retire();
        tick();
        chk("hold_dv_cycles", dv_count, 32'd6);
        chk("hold_stall_cnt", stall_cnt, 32'd12);

        // Flush while waiting for data; successor instruction waits for the drain.
        issue(32'h8000_0040, 4'b0000, 32'h0, 2'd2);
        tick();
        resp(1, 0, '0);
        tick();
        resp(0, 0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(32'h8000_0050, 4'b0000, 32'h0, 2'd2);
        #1;
        chk("drain_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        resp(0, 1, 32'h1111_1111);
        tick();
        resp(0, 0, '0);
        #1;
        chk("drain_m_data", m_data, 32'hA5A5_A5A5);
        chk("drain_stall_idle", {31'd0, mem_stall}, 32'd1);
        tick();
        chk("drain_reissue_valid", {31'd0, dreq_valid}, 32'd1);
        chk("drain_reissue_addr", dreq_addr, 32'h8000_0050);
        resp(1, 1, 32'h2222_2222);
        tick();
        resp(0, 0, '0);
        chk("drain_new_data", m_data, 32'h2222_2222);
        retire();

        // Flush in IDLE suppresses issue; flush coincident with data_ok drops the result.
        issue(32'h8000_0060, 4'b0000, 32'h0, 2'd2);
        flush = 1'b1;
        #1;
        chk("idle_flush_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("idle_flush_no_req", {31'd0, dreq_valid}, 32'd0);
        tick();
        resp(1, 1, 32'h3333_3333);
        flush = 1'b1;
        tick();
        resp(0, 0, '0);
        flush = 1'b0; m_vreq = 1'b0;
        #1;
        chk("coflush_m_data", m_data, 32'h2222_2222);
        chk("coflush_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        issue(32'h8000_0070, 4'b0000, 32'h0, 2'd2);
        tick();
        resp(1, 1, 32'h4444_4444);
        tick();
        resp(0, 0, '0);
        chk("after_coflush_data", m_data, 32'h4444_4444);
        retire();

        // Reset in the middle of a transaction.
        issue(32'h8000_0080, 4'b0000, 32'h0, 2'd2);
        tick();
        resp(1, 0, '0);
        tick();
        resp(0, 0, '0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1; m_vreq = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, dreq_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
        chk("mid_rst_m_data", m_data, 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
